mul_div_unit: RTL

- Iterative multiply/divide unit on the ALU side of the datapath, downstream of the immediate extenders and register file.
- Operand B arrives from the ALUSrc mux, so it is either a register value or the 32-bit extended immediate.
- Executes MULTU/MULT/DIVU/DIV over a fixed number of cycles with a start/busy/done handshake.
- Holds results in HI/LO registers until the next accepted operation.

---
 rtl/mul_div_unit_pkg.sv | 22 ++
 rtl/mul_div_unit_if.sv | 17 +
 rtl/mul_div_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mul_div_unit_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    FINISH = 2'b10
  } state_e;

  // Quotient reported on divide by zero.
  localparam logic [WIDTH_DEF-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the ALU issue logic and the multiply/divide unit.
interface mul_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             div_by_zero;

  modport master (output start, op, A, B,
                  input  busy, done, HI, LO, div_by_zero);
  modport slave  (input  start, op, A, B,
                  output busy, done, HI, LO, div_by_zero);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULTU/MULT/DIVU/DIV: one shift-add or restoring-divide step per cycle,
// results held in HI/LO until the next accepted operation.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     a_raw_q, a_raw_d;
  logic                 sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  logic                 busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH-1:0]     acc_hi, acc_lo, mag_a, mag_b, quo, rem;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod;
  logic                 in_sa, in_sb;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  always_comb begin
    in_sa  = bus.op[0] & bus.A[WIDTH-1];
    in_sb  = bus.op[0] & bus.B[WIDTH-1];
    mag_a  = mag(bus.A, in_sa);
    mag_b  = mag(bus.B, in_sb);
    acc_hi = acc_q[2*WIDTH-1:WIDTH];
    acc_lo = acc_q[WIDTH-1:0];
    // Multiply: multiplier sits in the low half and is consumed LSB first.
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_lo[WIDTH-1:1]};
    // Divide: partial remainder can briefly need one extra bit after the shift.
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_shift >= {1'b0, opnd_q})
      div_next = {div_diff[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
    else
      div_next = {div_shift[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
    prod = (op_q == OP_MULT && (sa_q ^ sb_q)) ? -acc_q : acc_q;
    quo  = (op_q == OP_DIV && (sa_q ^ sb_q)) ? -acc_lo : acc_lo;
    rem  = (op_q == OP_DIV && sa_q) ? -acc_hi : acc_hi;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    a_raw_d = a_raw_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = op_e'(bus.op);
          sa_d    = in_sa;
          sb_d    = in_sb;
          a_raw_d = bus.A;
          bz_d    = (bus.B == '0);
          if (bus.op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, mag_a};
            opnd_d = mag_b;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, mag_b};
            opnd_d = mag_a;
          end
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
      end
      FINISH: begin
        if (!op_q[1]) begin
          hi_d  = prod[2*WIDTH-1:WIDTH];
          lo_d  = prod[WIDTH-1:0];
          dbz_d = 1'b0;
        end else if (bz_q) begin
          hi_d  = a_raw_q;
          lo_d  = WIDTH'(DIV0_QUOT);
          dbz_d = 1'b1;
        end else begin
          hi_d  = rem;
          lo_d  = quo;
          dbz_d = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_MULTU;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      a_raw_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      a_raw_q <= a_raw_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.HI          = hi_q;
  assign bus.LO          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule
